// File: rtl/pulse_meter_pkg.sv
// Shared lab header: FSM state encodings and small helpers used by the
// timer/counter family and pulse_meter.
package pulse_meter_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MEAS = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_MEAS = MEAS,
    ST_HOLD = HOLD
  } state_t;

  // Rising edge of a signal given its one-cycle-delayed copy.
  function automatic logic rise_of(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/pulse_meter_sat_counter.sv
// Saturating up-counter: load starts at 1, inc counts up or flags saturation
// at all-ones instead of wrapping.
module sat_counter #(
  parameter int counter_bits = 8
) (
  input  logic                    clk,
  input  logic                    r,
  input  logic                    load,
  input  logic                    inc,
  output logic [counter_bits-1:0] cnt,
  output logic                    sat
);

  localparam logic [counter_bits-1:0] CNT_ONE  = {{(counter_bits-1){1'b0}}, 1'b1};
  localparam logic [counter_bits-1:0] CNT_ZERO = {counter_bits{1'b0}};

  logic [counter_bits-1:0] cnt_q, cnt_d;
  logic                    sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (load) begin
      cnt_d = CNT_ONE;
      sat_d = 1'b0;
    end else if (inc) begin
      if (&cnt_q) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      cnt_q <= CNT_ZERO;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/pulse_meter.sv
// Measures the width of a high pulse on sig and holds the result behind a
// valid/ack handshake; rising edges seen while a result is held set miss.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int counter_bits = 8
) (
  input  logic                    clk,
  input  logic                    r,
  input  logic                    en,
  input  logic                    sig,
  input  logic                    ack,
  output logic [counter_bits-1:0] q,
  output logic                    valid,
  output logic                    ovf,
  output logic                    miss
);

  state_t                  state_q, state_d;
  logic                    sig_dly_q;
  logic [counter_bits-1:0] q_q, q_d;
  logic                    valid_q, valid_d;
  logic                    ovf_q, ovf_d;
  logic                    miss_q, miss_d;
  logic                    rise_s;
  logic                    load_s;
  logic                    inc_s;
  logic [counter_bits-1:0] cnt_s;
  logic                    sat_s;

  assign rise_s = rise_of(sig, sig_dly_q);

  sat_counter #(.counter_bits(counter_bits)) u_cnt (
    .clk  (clk),
    .r    (r),
    .load (load_s),
    .inc  (inc_s),
    .cnt  (cnt_s),
    .sat  (sat_s)
  );

  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    inc_s   = 1'b0;
    q_d     = q_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    miss_d  = miss_q;
    case (state_q)
      ST_IDLE: begin
        if (en && rise_s) begin
          load_s  = 1'b1;
          state_d = ST_MEAS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEAS: begin
        // Abort takes priority over the falling edge that would end the pulse.
        if (!en) begin
          state_d = ST_IDLE;
        end else if (sig) begin
          inc_s = 1'b1;
        end else begin
          q_d     = cnt_s;
          ovf_d   = sat_s;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ack) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
        if (rise_s) begin
          miss_d = 1'b1;
        end else begin
          miss_d = miss_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // sig_dly_q resets high so a signal already high at reset release is ignored.
  always_ff @(posedge clk) begin
    if (!r) begin
      state_q   <= ST_IDLE;
      sig_dly_q <= 1'b1;
      q_q       <= {counter_bits{1'b0}};
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sig_dly_q <= sig;
      q_q       <= q_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      miss_q    <= miss_d;
    end
  end

  assign q     = q_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign miss  = miss_q;

endmodule
